// File: rtl/seq_detect_pkg.sv
// -----------------------------------------------------------------------------
// seq_detect_pkg
// Shared definitions for the programmable serial pattern-detect controller:
// FSM state encoding, power-on configuration defaults, and a helper that
// decides whether a stored pattern length can be armed.
// -----------------------------------------------------------------------------
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;
  localparam int         DEFAULT_LEN     = 4;
  localparam logic       DEFAULT_OVERLAP = 1'b1;

  // A pattern can be armed only if it has at least one bit and fits the
  // history register.
  function automatic logic len_legal(input int len, input int max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_shift_match.sv
// -----------------------------------------------------------------------------
// seq_shift_match
// History shift register, fill counter and length-masked pattern compare.
// hit is combinational and reflects the state the registers are about to
// take, so the caller can register it and get a match pulse one cycle after
// the completing bit.
//
// Ports
//   clk       in   1      clock, posedge
//   rst       in   1      synchronous active-high reset
//   shift_en  in   1      accept bit_in this cycle
//   clr       in   1      forget history and fill (start/stop)
//   overlap   in   1      1 = keep fill after a hit, 0 = restart after a hit
//   bit_in    in   1      serial bit, shifted in at bit 0
//   len       in   LEN_W  active pattern length (1..PAT_W)
//   pattern   in   PAT_W  pattern, bit [len-1] oldest, bit [0] newest
//   hit       out  1      history-to-be matches the pattern
// -----------------------------------------------------------------------------
module seq_shift_match
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int LEN_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             overlap,
  input  logic             bit_in,
  input  logic [LEN_W-1:0] len,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);

  logic [PAT_W-1:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic [PAT_W-1:0] w_hist_next;
  logic [LEN_W-1:0] w_fill_next;
  logic [PAT_W-1:0] w_mask;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    w_hist_next = {r_hist[PAT_W-2:0], bit_in};
    w_fill_next = (r_fill == FILL_MAX) ? r_fill : r_fill + LEN_W'(1);
    w_mask      = '0;
    for (int i = 0; i < PAT_W; i++) begin
      w_mask[i] = (LEN_W'(i) < len);
    end
    // Only compare once at least len bits have been seen since the last clear.
    hit = shift_en && (w_fill_next >= len) &&
          ((w_hist_next & w_mask) == (pattern & w_mask));
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (shift_en) begin
      r_hist <= w_hist_next;
      // Without overlap the bits of a match may not start the next one;
      // clearing fill is enough, the stale history is masked out by fill.
      r_fill <= (hit && !overlap) ? '0 : w_fill_next;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// -----------------------------------------------------------------------------
// seq_detect_ctrl
// Programmable serial pattern-detect controller. Holds a runtime-loaded
// pattern, arms/disarms detection on a qualified bit stream, counts matches
// and stops when a target count is reached.
//
// Ports
//   clk          in   1      clock, posedge
//   rst          in   1      synchronous active-high reset
//   cfg_we       in   1      load configuration (ignored while ARMED)
//   cfg_pattern  in   PAT_W  pattern, bit [len-1] received first
//   cfg_len      in   LEN_W  pattern length, legal 1..PAT_W
//   cfg_overlap  in   1      1 = overlapping matches allowed
//   cfg_target   in   CNT_W  match count ending the run, 0 = free-run
//   start        in   1      arm detection (pulse)
//   stop         in   1      disarm detection (pulse), wins over start
//   bit_valid    in   1      qualifier for bit_in
//   bit_in       in   1      serial data bit
//   match        out  1      1-cycle pulse per detected match
//   match_count  out  CNT_W  matches this run, saturating
//   busy         out  1      detection armed
//   done         out  1      target reached
//   cfg_err      out  1      1-cycle pulse: config write or start rejected
// -----------------------------------------------------------------------------
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int LEN_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             stop,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam logic [PAT_W-1:0] RST_PATTERN = PAT_W'(DEFAULT_PATTERN);
  localparam logic [LEN_W-1:0] RST_LEN =
    LEN_W'((PAT_W < DEFAULT_LEN) ? PAT_W : DEFAULT_LEN);

  state_e           r_state;
  logic [PAT_W-1:0] r_pattern;
  logic [LEN_W-1:0] r_len;
  logic             r_overlap;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_count;
  logic             r_match;
  logic             r_cfg_err;

  logic             w_armed;
  logic             w_cfg_ok;
  logic [LEN_W-1:0] w_eff_len;
  logic             w_start_req;
  logic             w_start_ok;
  logic             w_shift_en;
  logic             w_clr;
  logic             w_hit;
  logic [CNT_W-1:0] w_count_next;
  logic             w_hit_target;
  logic             w_cfg_err;

  always_comb begin
    w_armed     = (r_state == ARMED);
    w_cfg_ok    = cfg_we && !w_armed;
    // A start issued together with a config write is judged on the new length.
    w_eff_len   = w_cfg_ok ? cfg_len : r_len;
    w_start_req = start && !stop && !w_armed;
    w_start_ok  = w_start_req && len_legal(int'(w_eff_len), PAT_W);
    w_shift_en  = w_armed && bit_valid && !stop;
    w_clr       = stop || w_start_ok;
    w_cfg_err   = (cfg_we && w_armed) ||
                  (w_start_req && !len_legal(int'(w_eff_len), PAT_W));
    w_count_next = (r_count == '1) ? r_count : r_count + CNT_W'(1);
    w_hit_target = (r_target != '0) && (w_count_next == r_target);
  end

  seq_shift_match #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_shift_match (
    .clk      (clk),
    .rst      (rst),
    .shift_en (w_shift_en),
    .clr      (w_clr),
    .overlap  (r_overlap),
    .bit_in   (bit_in),
    .len      (r_len),
    .pattern  (r_pattern),
    .hit      (w_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pattern <= RST_PATTERN;
      r_len     <= RST_LEN;
      r_overlap <= DEFAULT_OVERLAP;
      r_target  <= '0;
      r_count   <= '0;
      r_match   <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_match   <= w_hit;
      r_cfg_err <= w_cfg_err;

      if (w_cfg_ok) begin
        r_pattern <= cfg_pattern;
        r_len     <= cfg_len;
        r_overlap <= cfg_overlap;
        r_target  <= cfg_target;
      end

      // stop leaves the count alone so the host can read the last run.
      if (w_start_ok) begin
        r_count <= '0;
      end else if (w_hit) begin
        r_count <= w_count_next;
      end

      case (r_state)
        IDLE:    if (w_start_ok) r_state <= ARMED;
        ARMED: begin
          if (stop)                       r_state <= IDLE;
          else if (w_hit && w_hit_target) r_state <= DONE;
        end
        DONE: begin
          if (stop)            r_state <= IDLE;
          else if (w_start_ok) r_state <= ARMED;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign match       = r_match;
  assign match_count = r_count;
  assign busy        = (r_state == ARMED);
  assign done        = (r_state == DONE);
  assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_ctrl
// Drives directed and random stimulus into seq_detect_ctrl. Each driven cycle
// runs a queue-based reference model and pushes the expected post-edge
// outputs into a scoreboard; an independent monitor pops and compares them
// shortly after every rising edge.
// -----------------------------------------------------------------------------
module tb_seq_detect_ctrl;

  localparam int PAT_W = 4;
  localparam int LEN_W = 3;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cfg_we = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic [CNT_W-1:0] cfg_target = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             bit_valid = 1'b0;
  logic             bit_in = 1'b0;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             busy;
  logic             done;
  logic             cfg_err;

  seq_detect_ctrl #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .start       (start),
    .stop        (stop),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .match       (match),
    .match_count (match_count),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             match;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Reference model: 0 = idle, 1 = armed, 2 = done. History is simply the
  // list of bits received since the last clear, capped at PAT_W entries.
  int         m_state;
  logic [3:0] m_pat;
  int         m_len;
  bit         m_ovl;
  int         m_tgt;
  int         m_count;
  bit         m_hist[$];

  task automatic check(input string name, input logic ok, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s cycle %0d: %s", name, cyc, detail);
    end
  endtask

  task automatic model_step(output exp_t e);
    bit same;
    e = '0;
    if (rst) begin
      m_state = 0; m_pat = 4'b1101; m_len = 4; m_ovl = 1; m_tgt = 0;
      m_count = 0; m_hist.delete();
    end else begin
      if (cfg_we) begin
        if (m_state == 1) e.err = 1'b1;
        else begin
          m_pat = cfg_pattern; m_len = int'(cfg_len);
          m_ovl = cfg_overlap; m_tgt = int'(cfg_target);
        end
      end
      if (stop) begin
        m_state = 0;
        m_hist.delete();
      end else if (start && m_state != 1) begin
        if (m_len >= 1 && m_len <= PAT_W) begin
          m_state = 1; m_count = 0; m_hist.delete();
        end else begin
          e.err = 1'b1;
        end
      end else if (m_state == 1 && bit_valid) begin
        m_hist.push_back(bit_in);
        if (m_hist.size() > PAT_W) void'(m_hist.pop_front());
        if (m_hist.size() >= m_len) begin
          same = 1;
          for (int k = 0; k < m_len; k++)
            if (m_hist[m_hist.size() - 1 - k] != m_pat[k]) same = 0;
          if (same) begin
            e.match = 1'b1;
            if (m_count < 255) m_count++;
            if (!m_ovl) m_hist.delete();
            if (m_tgt != 0 && m_count == m_tgt) m_state = 2;
          end
        end
      end
    end
    e.count = m_count[CNT_W-1:0];
    e.busy  = (m_state == 1);
    e.done  = (m_state == 2);
  endtask

  // One driven cycle: inputs are already set; predict, queue, advance.
  task automatic tick();
    exp_t e;
    model_step(e);
    exp_q.push_back(e);
    @(negedge clk);
    rst = 0; cfg_we = 0; start = 0; stop = 0; bit_valid = 0; bit_in = 0;
  endtask

  task automatic do_cfg(input logic [3:0] p, input int l, input bit o, input int t);
    cfg_we = 1; cfg_pattern = p; cfg_len = LEN_W'(l);
    cfg_overlap = o; cfg_target = CNT_W'(t);
    tick();
  endtask

  task automatic do_start(); start = 1; tick(); endtask
  task automatic do_stop();  stop = 1;  tick(); endtask
  task automatic do_rst();   rst = 1;   tick(); endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Sends n bits, most significant (first received) first.
  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1;
      bit_in = bits[n - 1 - i];
      tick();
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard after each edge.
  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("outputs",
            {match, match_count, busy, done, cfg_err} == mon_e,
            $sformatf("got m=%b cnt=%0d busy=%b done=%b err=%b, want m=%b cnt=%0d busy=%b done=%b err=%b",
                      match, match_count, busy, done, cfg_err,
                      mon_e.match, mon_e.count, mon_e.busy, mon_e.done, mon_e.err));
    end
  end

  initial begin
    do_rst();
    do_rst();

    // Default pattern 1101 with overlap: matches after bits 4 and 7.
    do_start();
    send_bits(16'b1101101, 7);
    idle(1);

    // Pattern 101, non-overlapping then overlapping.
    do_stop();
    do_cfg(4'b0101, 3, 0, 0);
    do_start();
    send_bits(16'b10101, 5);
    do_stop();
    do_cfg(4'b0101, 3, 1, 0);
    do_start();
    send_bits(16'b10101, 5);

    // Target 3 on single-bit pattern; fourth bit must be ignored.
    do_stop();
    do_cfg(4'b0001, 1, 1, 3);
    do_start();
    send_bits(16'b1111, 4);
    idle(2);

    // Config write while armed is rejected; old pattern keeps matching.
    do_start();
    do_cfg(4'b0000, 2, 0, 0);
    send_bits(16'b1, 1);

    // Zero length cannot be armed.
    do_stop();
    do_cfg(4'b0000, 0, 1, 0);
    do_start();
    idle(1);
    do_cfg(4'b1101, 5, 1, 0);
    do_start();

    // start and stop together: stop wins.
    do_cfg(4'b1101, 4, 1, 0);
    start = 1; stop = 1; tick();
    idle(1);

    // Partial pattern forgotten across stop/start.
    do_start();
    send_bits(16'b110, 3);
    do_stop();
    do_start();
    send_bits(16'b1, 1);
    send_bits(16'b1101, 4);

    // bit_valid gaps inside 1101.
    do_stop();
    do_start();
    send_bits(16'b1, 1); idle(1);
    send_bits(16'b1, 1); idle(2);
    send_bits(16'b0, 1); idle(1);
    send_bits(16'b1, 1);

    // Reset mid-run, then config write and start in the same cycle.
    send_bits(16'b11, 2);
    do_rst();
    cfg_we = 1; cfg_pattern = 4'b0010; cfg_len = 3'd2; cfg_overlap = 0;
    cfg_target = 8'd0; start = 1;
    tick();
    send_bits(16'b1010, 4);

    // Free-run saturation of the match counter.
    do_stop();
    do_cfg(4'b0001, 1, 1, 0);
    do_start();
    for (int i = 0; i < 258; i++) send_bits(16'b1, 1);

    // Random traffic.
    do_stop();
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 999) < 3);
      cfg_we    = ($urandom_range(0, 99) < 3);
      if (cfg_we) begin
        cfg_pattern = PAT_W'($urandom);
        cfg_len     = ($urandom_range(0, 9) == 0) ? LEN_W'($urandom_range(0, 7))
                                                  : LEN_W'($urandom_range(1, PAT_W));
        cfg_overlap = 1'($urandom);
        cfg_target  = CNT_W'($urandom_range(0, 5));
      end
      start     = ($urandom_range(0, 99) < 4);
      stop      = ($urandom_range(0, 99) < 2);
      bit_valid = ($urandom_range(0, 99) < 80);
      bit_in    = 1'($urandom);
      tick();
    end

    idle(2);
    @(posedge clk);
    #2;
    check("drain", exp_q.size() == 0,
          $sformatf("got %0d pending expectations, want 0", exp_q.size()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
